uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single UART transmitter (`we` / `data_in` byte-load port, serial out on `uart_rxd_out`) between `N_REQ` byte sources. It accepts bytes from requesters over a req/ack handshake, issues each byte to the transmitter as a one-cycle write strobe, and waits for the transmitter to finish before issuing the next. Packets (multi-byte messages) are kept contiguous by a grant lock, with a timeout that releases a stalled lock. It sits in `top` between the message producers and the UART TX datapath.

---
 rtl/uart_tx_arbiter_if.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Purpose: requester/transmitter side bundle of the UART TX arbiter.
// Latency: none; this is wiring only, every output is registered inside the arbiter.
// Backpressure: req is held until ack; tx_busy from the transmitter stalls issue.
interface uart_tx_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    localparam int GID_W = $clog2(N_REQ);

    // requester side
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        ack;

    // transmitter side
    logic                    tx_we;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_busy;

    // status
    logic [GID_W-1:0]        grant_id;
    logic                    locked;

    // master: the surrounding system (requesters plus the transmitter)
    modport master (
        output req, req_data, req_last, tx_busy,
        input  ack, tx_we, tx_data, grant_id, locked
    );

    // slave: the arbiter itself
    modport slave (
        input  req, req_data, req_last, tx_busy,
        output ack, tx_we, tx_data, grant_id, locked
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin arbiter sharing one UART transmitter between N_REQ byte sources, with packet lock.
// Latency: req sampled in IDLE with tx_busy low at cycle t gives tx_we and ack at t+1.
// Backpressure: nothing issues while tx_busy is high; bytes spaced 3 cycles plus busy time; stalled lock times out.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = 8,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_arbiter_if.slave    bus
);
    localparam int GID_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]        r_state;
    logic [GID_W-1:0]  r_rr_ptr;
    logic [GID_W-1:0]  r_grant_id;
    logic              r_locked;
    logic              r_last_q;
    logic              r_tx_we;
    logic [DATA_W-1:0] r_tx_data;
    logic [N_REQ-1:0]  r_ack;
    logic [CNT_W-1:0]  r_idle_cnt;

    logic              w_sel_vld;
    logic [GID_W-1:0]  w_sel_idx;
    logic [N_REQ-1:0]  w_sel_onehot;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_last;
    logic              w_to_cond;
    logic              w_to_expire;

    // Index after i, wrapping at N_REQ (which need not be a power of two).
    function automatic logic [GID_W-1:0] f_next(input logic [GID_W-1:0] i);
        if (i == GID_W'(N_REQ - 1)) begin
            return '0;
        end
        return i + GID_W'(1);
    endfunction

    // Requester selection: the locked owner only, else first set req scanning up from rr_ptr.
    always_comb begin
        int unsigned v_idx;
        w_sel_vld = 1'b0;
        w_sel_idx = '0;
        v_idx     = 0;
        if (r_locked) begin
            w_sel_vld = bus.req[r_grant_id];
            w_sel_idx = r_grant_id;
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                v_idx = int'(r_rr_ptr) + k;
                if (v_idx >= N_REQ) begin
                    v_idx = v_idx - N_REQ;
                end
                // descending scan so the closest hit to rr_ptr is written last and wins
                if (bus.req[v_idx]) begin
                    w_sel_vld = 1'b1;
                    w_sel_idx = v_idx[GID_W-1:0];
                end
            end
        end
    end

    // Data/last mux and one-hot ack vector for the selected requester.
    always_comb begin
        w_sel_onehot            = '0;
        w_sel_onehot[w_sel_idx] = 1'b1;
        w_sel_data              = bus.req_data[w_sel_idx*DATA_W +: DATA_W];
        w_sel_last              = bus.req_last[w_sel_idx];
    end

    // The lock owner counts as stalled only while we sit in IDLE without its request.
    assign w_to_cond   = (r_state == S_IDLE) && r_locked && !bus.req[r_grant_id];
    assign w_to_expire = w_to_cond && (r_idle_cnt == CNT_W'(LOCK_TIMEOUT - 1));

    // Stall counter for the lock owner; any non-stalled cycle restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (!w_to_cond || w_to_expire) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + CNT_W'(1);
        end
    end

    // Main sequencer: select in IDLE, strobe in ISSUE, skip the busy-rise cycle, drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_locked   <= 1'b0;
            r_last_q   <= 1'b0;
            r_tx_we    <= 1'b0;
            r_tx_data  <= '0;
            r_ack      <= '0;
        end else begin
            // strobes are single-cycle by default
            r_tx_we <= 1'b0;
            r_ack   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_to_expire) begin
                        // stalled packet: reopen arbitration after the owner
                        r_locked <= 1'b0;
                        r_rr_ptr <= f_next(r_grant_id);
                    end else if (!bus.tx_busy && w_sel_vld) begin
                        r_tx_data  <= w_sel_data;
                        r_last_q   <= w_sel_last;
                        r_grant_id <= w_sel_idx;
                        r_tx_we    <= 1'b1;
                        r_ack      <= w_sel_onehot;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_last_q) begin
                        r_locked <= 1'b0;
                        r_rr_ptr <= f_next(r_grant_id);
                    end else begin
                        r_locked <= 1'b1;
                    end
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    // the transmitter raises tx_busy only now, so it is not trusted yet
                    r_state <= S_DRAIN;
                end
                default: begin
                    if (!bus.tx_busy) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.tx_we    = r_tx_we;
    assign bus.tx_data  = r_tx_data;
    assign bus.ack      = r_ack;
    assign bus.grant_id = r_grant_id;
    assign bus.locked   = r_locked;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: self-checking bench for uart_tx_arbiter with a simple transmitter busy model.
// Latency: checks tx_we/ack one cycle after a sampled request in IDLE.
// Backpressure: transmitter holds tx_busy for BUSY_LEN cycles after each strobe, plus a forced stall.
module tb_uart_tx_arbiter;
    localparam int N        = 4;
    localparam int W        = 8;
    localparam int TO       = 16;
    localparam int BUSY_LEN = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .LOCK_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // transmitter model: busy starts the cycle after the strobe and lasts BUSY_LEN cycles
    int   busy_cnt   = 0;
    logic force_busy = 1'b0;
    always @(posedge clk) begin
        if (bus.tx_we) busy_cnt <= BUSY_LEN;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.tx_busy = (busy_cnt != 0) || force_busy;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  last;
        logic [7:0]  exp_data;
        logic [3:0]  exp_ack;
        logic [1:0]  exp_gid;
        logic        exp_locked;
    } vec_t;

    vec_t tbl[11];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // advance until tx_we is seen (bounded), leaving time in the ISSUE cycle
    task automatic wait_tx(input string name);
        int n;
        n = 0;
        step();
        while (!bus.tx_we && n < 200) begin
            step();
            n++;
        end
        chk({name, "_tx_we"}, {31'b0, bus.tx_we}, 32'd1);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_last = '0;
        bus.req_data = '0;
        force_busy   = 1'b0;
        repeat (BUSY_LEN + 2) step();
        rst = 1'b0;
    endtask

    initial begin
        int we_seen;
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_last = '0;

        // fairness, then a locked packet from requester 1 racing requesters 0 and 2
        tbl[0]  = '{4'hF,    32'hA3A2A1A0, 4'hF,    8'hA0, 4'b0001, 2'd0, 1'b0};
        tbl[1]  = '{4'hF,    32'hA3A2A1A0, 4'hF,    8'hA1, 4'b0010, 2'd1, 1'b0};
        tbl[2]  = '{4'hF,    32'hA3A2A1A0, 4'hF,    8'hA2, 4'b0100, 2'd2, 1'b0};
        tbl[3]  = '{4'hF,    32'hA3A2A1A0, 4'hF,    8'hA3, 4'b1000, 2'd3, 1'b0};
        tbl[4]  = '{4'hF,    32'hA3A2A1A0, 4'hF,    8'hA0, 4'b0001, 2'd0, 1'b0};
        tbl[5]  = '{4'b0100, 32'h00A20000, 4'b0100, 8'hA2, 4'b0100, 2'd2, 1'b0};
        tbl[6]  = '{4'b0010, 32'h00001100, 4'b0000, 8'h11, 4'b0010, 2'd1, 1'b1};
        tbl[7]  = '{4'b0111, 32'h00B222B0, 4'b0101, 8'h22, 4'b0010, 2'd1, 1'b1};
        tbl[8]  = '{4'b0111, 32'h00B233B0, 4'b0111, 8'h33, 4'b0010, 2'd1, 1'b0};
        tbl[9]  = '{4'b0101, 32'h00B200B0, 4'b0101, 8'hB2, 4'b0100, 2'd2, 1'b0};
        tbl[10] = '{4'b0001, 32'h000000B0, 4'b0001, 8'hB0, 4'b0001, 2'd0, 1'b0};

        do_reset();
        chk("rst_tx_we",    {31'b0, bus.tx_we},   32'd0);
        chk("rst_tx_data",  {24'b0, bus.tx_data}, 32'd0);
        chk("rst_ack",      {28'b0, bus.ack},     32'd0);
        chk("rst_grant_id", {30'b0, bus.grant_id}, 32'd0);
        chk("rst_locked",   {31'b0, bus.locked},  32'd0);

        // single byte: strobe exactly one cycle after the request is sampled
        bus.req_data[7:0] = 8'h2A;
        bus.req_last      = 4'b0001;
        bus.req           = 4'b0001;
        step();
        chk("single_tx_we",   {31'b0, bus.tx_we},   32'd1);
        chk("single_ack",     {28'b0, bus.ack},     32'h1);
        chk("single_tx_data", {24'b0, bus.tx_data}, 32'h2A);
        bus.req = '0;
        step();
        chk("single_we_drop",  {31'b0, bus.tx_we},   32'd0);
        chk("single_ack_drop", {28'b0, bus.ack},     32'd0);
        chk("single_locked",   {31'b0, bus.locked},  32'd0);
        chk("single_hold",     {24'b0, bus.tx_data}, 32'h2A);
        // next scan begins at requester 1
        bus.req_data = 32'h00002C2B;
        bus.req_last = 4'b0011;
        bus.req      = 4'b0011;
        wait_tx("scan");
        chk("scan_ack",  {28'b0, bus.ack},     32'h2);
        chk("scan_data", {24'b0, bus.tx_data}, 32'h2C);
        bus.req = '0;

        do_reset();
        for (int i = 0; i < 11; i++) begin
            bus.req_data = tbl[i].data;
            bus.req_last = tbl[i].last;
            bus.req      = tbl[i].req;
            wait_tx($sformatf("row%0d", i));
            chk($sformatf("row%0d_data", i), {24'b0, bus.tx_data},  {24'b0, tbl[i].exp_data});
            chk($sformatf("row%0d_ack", i),  {28'b0, bus.ack},      {28'b0, tbl[i].exp_ack});
            chk($sformatf("row%0d_gid", i),  {30'b0, bus.grant_id}, {30'b0, tbl[i].exp_gid});
            step();
            chk($sformatf("row%0d_locked", i), {31'b0, bus.locked}, {31'b0, tbl[i].exp_locked});
        end
        bus.req = '0;

        // lock timeout: owner 1 stalls mid-packet, requester 3 waits
        do_reset();
        bus.req_data = 32'h77005500;
        bus.req_last = 4'b1000;
        bus.req      = 4'b1010;
        wait_tx("to_first");
        chk("to_first_data", {24'b0, bus.tx_data}, 32'h55);
        chk("to_first_ack",  {28'b0, bus.ack},     32'h2);
        step();
        bus.req = 4'b1000;
        chk("to_locked", {31'b0, bus.locked}, 32'd1);
        repeat (20) step();
        chk("to_lock_hold",  {31'b0, bus.locked}, 32'd1);
        step();
        chk("to_unlock",     {31'b0, bus.locked}, 32'd0);
        chk("to_no_we_yet",  {31'b0, bus.tx_we},  32'd0);
        step();
        chk("to_r3_we",   {31'b0, bus.tx_we},    32'd1);
        chk("to_r3_ack",  {28'b0, bus.ack},      32'h8);
        chk("to_r3_data", {24'b0, bus.tx_data},  32'h77);
        chk("to_r3_gid",  {30'b0, bus.grant_id}, 32'd3);
        bus.req = '0;
        repeat (8) step();

        // back-pressure: long busy blocks issue, strobe one cycle after it falls
        force_busy        = 1'b1;
        bus.req_data[23:16] = 8'hC2;
        bus.req_last      = 4'b0100;
        bus.req           = 4'b0100;
        we_seen = 0;
        repeat (100) begin
            step();
            if (bus.tx_we) we_seen++;
        end
        chk("bp_no_we", we_seen, 32'd0);
        force_busy = 1'b0;
        step();
        chk("bp_we",   {31'b0, bus.tx_we},   32'd1);
        chk("bp_data", {24'b0, bus.tx_data}, 32'hC2);
        chk("bp_ack",  {28'b0, bus.ack},     32'h4);
        bus.req = '0;
        repeat (8) step();

        // reset in DRAIN while locked
        bus.req_data = 32'h00001000;
        bus.req_last = 4'b0000;
        bus.req      = 4'b0010;
        wait_tx("rmp");
        chk("rmp_ack", {28'b0, bus.ack}, 32'h2);
        step();
        bus.req = '0;
        step();
        chk("rmp_locked", {31'b0, bus.locked}, 32'd1);
        rst = 1'b1;
        step();
        chk("rmp_tx_we",   {31'b0, bus.tx_we},    32'd0);
        chk("rmp_ack0",    {28'b0, bus.ack},      32'd0);
        chk("rmp_tx_data", {24'b0, bus.tx_data},  32'd0);
        chk("rmp_gid",     {30'b0, bus.grant_id}, 32'd0);
        chk("rmp_unlock",  {31'b0, bus.locked},   32'd0);
        rst          = 1'b0;
        bus.req_data = 32'hD3D20000;
        bus.req_last = 4'b1100;
        bus.req      = 4'b1100;
        wait_tx("rmp_after");
        chk("rmp_after_ack",  {28'b0, bus.ack},      32'h4);
        chk("rmp_after_data", {24'b0, bus.tx_data},  32'hD2);
        chk("rmp_after_gid",  {30'b0, bus.grant_id}, 32'd2);
        bus.req = '0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
